// File: rtl/l1c_data_assoc.sv
// l1c_data_assoc: N-way set-associative L1 data cache, write-through,
// no-write-allocate, round-robin victim per set, single-cycle full flush.
// Tag, data and valid storage are internal flop arrays.
//
// Optional feature macro: L1C_PERF_CNT_EN
//   defined   -> hit_cnt/miss_cnt count lookups (wrap at 2^32, reset only)
//   undefined -> hit_cnt/miss_cnt tied to 0, no counter flops
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   core_req/write/addr/in/type/flush   core request side (held while core_wait)
//   core_out, core_wait    load data (valid in DONE), stall
//   D_req/addr/write/in/type            memory request side (word beats)
//   D_out, D_wait          memory read data, memory stall
//   hit_cnt, miss_cnt      performance counters
module l1c_data_assoc #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_req,
  input  logic                 core_write,
  input  logic [ADDR_BITS-1:0] core_addr,
  input  logic [DATA_BITS-1:0] core_in,
  input  logic [2:0]           core_type,
  input  logic                 core_flush,
  output logic [DATA_BITS-1:0] core_out,
  output logic                 core_wait,
  output logic                 D_req,
  output logic [ADDR_BITS-1:0] D_addr,
  output logic                 D_write,
  output logic [DATA_BITS-1:0] D_in,
  output logic [2:0]           D_type,
  input  logic [DATA_BITS-1:0] D_out,
  input  logic                 D_wait,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);
  localparam int WO  = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_BITS - IDX - WO - 2;
  localparam int VW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] T_BYTE    = 3'b000;
  localparam logic [2:0] T_HWORD   = 3'b001;
  localparam logic [2:0] T_BYTE_U  = 3'b100;
  localparam logic [2:0] T_HWORD_U = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_DONE} state_t;
  state_t state, state_nx;

  // registered request
  logic [ADDR_BITS-1:0] addr_q;
  logic                 write_q;
  logic [DATA_BITS-1:0] in_q;
  logic [2:0]           type_q;

  logic [WO-1:0]        beat_q;
  logic [DATA_BITS-1:0] rdata_q;

  // storage
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][VW-1:0]   vptr_q;
  logic [TAG-1:0]            tag_q  [WAYS][SETS];
  logic [DATA_BITS-1:0]      data_q [WAYS][SETS][LINE_WORDS];

  // request field decode
  logic [TAG-1:0] tag_f;
  logic [IDX-1:0] idx_f;
  logic [WO-1:0]  off_f;
  assign tag_f = addr_q[ADDR_BITS-1 -: TAG];
  assign idx_f = addr_q[2+WO +: IDX];
  assign off_f = addr_q[2 +: WO];

  logic          hit;
  logic [VW-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_f][w] && (tag_q[w][idx_f] == tag_f)) begin
        hit     = 1'b1;
        hit_way = VW'(w);
      end
    end
  end

  logic          last_beat;
  logic [VW-1:0] victim, victim_nx;
  assign last_beat = &beat_q;
  assign victim    = vptr_q[idx_f];
  assign victim_nx = (WAYS == 1) ? '0 : VW'(victim + 1'b1);

  // store byte merge into the hit word
  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
    case (t)
      T_BYTE, T_BYTE_U:   byte_en = 4'b0001 << a;
      T_HWORD, T_HWORD_U: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default:            byte_en = 4'b1111;
    endcase
  endfunction

  logic [3:0]           be;
  logic [DATA_BITS-1:0] old_word, merged;
  assign be       = byte_en(type_q, addr_q[1:0]);
  assign old_word = data_q[hit_way][idx_f][off_f];
  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = in_q[8*b +: 8];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!core_flush && core_req) state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = write_q ? S_WRITE : (hit ? S_DONE : S_REFILL);
      S_REFILL: if (!D_wait && last_beat) state_nx = S_DONE;
      S_WRITE:  if (!D_wait) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    core_wait = 1'b0;
    core_out  = '0;
    D_req     = 1'b0;
    D_write   = 1'b0;
    D_addr    = '0;
    case (state)
      S_IDLE:   core_wait = core_req & ~core_flush;
      S_LOOKUP: core_wait = 1'b1;
      S_REFILL: begin
        core_wait = 1'b1;
        D_req     = 1'b1;
        D_addr    = {addr_q[ADDR_BITS-1:2+WO], beat_q, 2'b00};
      end
      S_WRITE: begin
        core_wait = 1'b1;
        D_req     = 1'b1;
        D_write   = 1'b1;
        D_addr    = addr_q;
      end
      S_DONE:   core_out = rdata_q;
      default:  ;
    endcase
  end

  assign D_in   = in_q;
  assign D_type = type_q;

  // control state, valid bits and victim pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      in_q    <= '0;
      type_q  <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      valid_q <= '0;
      vptr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_flush) begin
            valid_q <= '0;
            vptr_q  <= '0;
          end else if (core_req) begin
            addr_q  <= core_addr;
            write_q <= core_write;
            in_q    <= core_in;
            type_q  <= core_type;
            beat_q  <= '0;
          end
        end
        S_LOOKUP: if (!write_q && hit) rdata_q <= old_word;
        S_REFILL: begin
          if (!D_wait) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == off_f) rdata_q <= D_out;
            // valid only once the whole line has landed
            if (last_beat) begin
              valid_q[idx_f][victim] <= 1'b1;
              vptr_q[idx_f]          <= victim_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data/tag arrays carry no reset; a victim line is written beat by beat
  // but only becomes visible when its valid bit is set on the last beat.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && write_q && hit)
      data_q[hit_way][idx_f][off_f] <= merged;
    if (state == S_REFILL && !D_wait) begin
      data_q[victim][idx_f][beat_q] <= D_out;
      if (last_beat) tag_q[victim][idx_f] <= tag_f;
    end
  end

`ifdef L1C_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
